// File: rtl/hazard_fwd_unit_if.sv
// Hazard/forwarding bundle between the CPU ID/EX boundary and hazard_fwd_unit.
//   master : CPU side. Drives the ID decode/read data and the EX/MEM/WB data values,
//            and receives the forwarded operands, selects and pipeline controls.
//   slave  : hazard_fwd_unit side.
// Signals:
//   id_valid, id_rs1/2, id_rs1/2_used, id_rd, id_rf_write, id_is_load, id_is_store,
//   id_branch_taken, id_hlt, id_rf1/2            -- ID stage decode and RF read data
//   ex_result, mem_data, wb_data                  -- candidate forwarding values
//   id_op1/2, fwd1/2_sel, st_fwd, stall, flush, hlt -- unit outputs
interface hazard_fwd_unit_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_AW = 4
);
   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_rs1_used;
   logic              id_rs2_used;
   logic [REG_AW-1:0] id_rd;
   logic              id_rf_write;
   logic              id_is_load;
   logic              id_is_store;
   logic              id_branch_taken;
   logic              id_hlt;
   logic [DATA_W-1:0] id_rf1;
   logic [DATA_W-1:0] id_rf2;
   logic [DATA_W-1:0] ex_result;
   logic [DATA_W-1:0] mem_data;
   logic [DATA_W-1:0] wb_data;
   logic [DATA_W-1:0] id_op1;
   logic [DATA_W-1:0] id_op2;
   logic [1:0]        fwd1_sel;
   logic [1:0]        fwd2_sel;
   logic              st_fwd;
   logic              stall;
   logic              flush;
   logic              hlt;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rf_write,
             id_is_load, id_is_store, id_branch_taken, id_hlt, id_rf1, id_rf2,
             ex_result, mem_data, wb_data,
      input  id_op1, id_op2, fwd1_sel, fwd2_sel, st_fwd, stall, flush, hlt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rf_write,
             id_is_load, id_is_store, id_branch_taken, id_hlt, id_rf1, id_rf2,
             ex_result, mem_data, wb_data,
      output id_op1, id_op2, fwd1_sel, fwd2_sel, st_fwd, stall, flush, hlt
   );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for a 5-stage pipeline (IF ID EX MEM WB).
// Tracks its own EX/MEM/WB destination tags, muxes forwarded ID operands, raises
// load-use stalls and branch flushes, forwards store data MEM->MEM, and drains the
// pipeline on a halt instruction.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : hazard_fwd_unit_if.slave (ID inputs, forwarding data, unit outputs)
// Optional feature macro: HAZ_STORE_FWD_EN -- a store whose data register is produced
// by the load directly ahead does not stall; st_fwd supplies the data in MEM instead.
module hazard_fwd_unit #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned REG_AW   = 4,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned DRAIN    = 3
) (
   input logic              clk,
   input logic              rst_n,
   hazard_fwd_unit_if.slave bus
);

   localparam int unsigned CNT_W = (DRAIN > 1) ? $clog2(DRAIN) : 1;

   typedef struct packed {
      logic              v;
      logic [REG_AW-1:0] rd;
      logic              wr;
      logic              ld;
      logic              st;
      logic [REG_AW-1:0] rs2;
   } tag_t;

   typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

   tag_t             ex_q, mem_q, wb_q;
   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             hlt_q;

   logic ex1, mem1, wb1, ex2, mem2, wb2;
   logic ld_hit1, ld_hit2, load_use;
   logic stall, flush, st_fwd;

   function automatic logic hits(input tag_t t, input logic [REG_AW-1:0] s, input logic used);
      return t.v & t.wr & (t.rd == s) & used & !((ZERO_REG != 0) && (s == '0));
   endfunction

   always_comb begin
      ex1  = hits(ex_q,  bus.id_rs1, bus.id_rs1_used);
      mem1 = hits(mem_q, bus.id_rs1, bus.id_rs1_used);
      wb1  = hits(wb_q,  bus.id_rs1, bus.id_rs1_used);
      ex2  = hits(ex_q,  bus.id_rs2, bus.id_rs2_used);
      mem2 = hits(mem_q, bus.id_rs2, bus.id_rs2_used);
      wb2  = hits(wb_q,  bus.id_rs2, bus.id_rs2_used);
      ld_hit1 = ex1 & ex_q.ld;
      ld_hit2 = ex2 & ex_q.ld;
`ifdef HAZ_STORE_FWD_EN
      // Store data hazard on rs2 alone is resolved later by st_fwd in MEM.
      load_use = ld_hit1 | (ld_hit2 & !bus.id_is_store);
`else
      load_use = ld_hit1 | ld_hit2;
`endif
   end

   // A loading EX match never forwards; selection falls through (the stall hides it).
   always_comb begin
      bus.fwd1_sel = 2'b00;
      if (ex1 && !ex_q.ld) bus.fwd1_sel = 2'b11;
      else if (mem1)       bus.fwd1_sel = 2'b10;
      else if (wb1)        bus.fwd1_sel = 2'b01;
      bus.fwd2_sel = 2'b00;
      if (ex2 && !ex_q.ld) bus.fwd2_sel = 2'b11;
      else if (mem2)       bus.fwd2_sel = 2'b10;
      else if (wb2)        bus.fwd2_sel = 2'b01;
   end

   always_comb begin
      case (bus.fwd1_sel)
         2'b11:   bus.id_op1 = bus.ex_result;
         2'b10:   bus.id_op1 = bus.mem_data;
         2'b01:   bus.id_op1 = bus.wb_data;
         default: bus.id_op1 = bus.id_rf1;
      endcase
      case (bus.fwd2_sel)
         2'b11:   bus.id_op2 = bus.ex_result;
         2'b10:   bus.id_op2 = bus.mem_data;
         2'b01:   bus.id_op2 = bus.wb_data;
         default: bus.id_op2 = bus.id_rf2;
      endcase
   end

`ifdef HAZ_STORE_FWD_EN
   assign st_fwd = mem_q.v & mem_q.st & wb_q.v & wb_q.wr & (wb_q.rd == mem_q.rs2) &
                   !((ZERO_REG != 0) && (mem_q.rs2 == '0));
`else
   assign st_fwd = 1'b0;
`endif

   assign stall = load_use | (state_q != StRun);
   assign flush = (state_q == StDrain) |
                  (bus.id_valid & bus.id_branch_taken & !stall & (state_q == StRun));

   assign bus.stall  = stall;
   assign bus.flush  = flush;
   assign bus.st_fwd = st_fwd;
   assign bus.hlt    = hlt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         // stall already covers the drain/halt states, so nothing new enters EX then.
         if (bus.id_valid && !stall) begin
            ex_q <= '{v: 1'b1, rd: bus.id_rd, wr: bus.id_rf_write, ld: bus.id_is_load,
                      st: bus.id_is_store, rs2: bus.id_rs2};
         end else begin
            ex_q <= '0;
         end
         mem_q <= ex_q;
         wb_q  <= mem_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StRun;
         cnt_q   <= '0;
         hlt_q   <= 1'b0;
      end else begin
         case (state_q)
            StRun: begin
               if (bus.id_valid && bus.id_hlt && !stall) begin
                  state_q <= StDrain;
                  cnt_q   <= CNT_W'(DRAIN - 1);
               end
            end
            StDrain: begin
               if (cnt_q == '0) begin
                  state_q <= StHalted;
                  hlt_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               state_q <= StHalted;
               hlt_q   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   hazard_fwd_unit_if #(.DATA_W(16), .REG_AW(4)) bus ();

   hazard_fwd_unit #(.DATA_W(16), .REG_AW(4), .ZERO_REG(1), .DRAIN(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_id();
      bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rs1_used = 0;
      bus.id_rs2_used = 0; bus.id_rd = 0; bus.id_rf_write = 0; bus.id_is_load = 0;
      bus.id_is_store = 0; bus.id_branch_taken = 0; bus.id_hlt = 0;
   endtask

   task automatic issue(input logic [3:0] rs1, input logic u1, input logic [3:0] rs2,
                        input logic u2, input logic [3:0] rd, input logic wr,
                        input logic ld, input logic st);
      clear_id();
      bus.id_valid = 1; bus.id_rs1 = rs1; bus.id_rs1_used = u1; bus.id_rs2 = rs2;
      bus.id_rs2_used = u2; bus.id_rd = rd; bus.id_rf_write = wr; bus.id_is_load = ld;
      bus.id_is_store = st;
   endtask

   // Leaves time at posedge+1, inputs then settle before the #1 checks.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_id();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
   endtask

   task automatic test_reset();
      clear_id();
      rst_n = 0;
      #3;
      checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", bus.stall); end
      checks++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL rst_flush got=%b exp=0", bus.flush); end
      checks++; if (bus.hlt !== 1'b0) begin failures++; $display("FAIL rst_hlt got=%b exp=0", bus.hlt); end
      checks++; if (bus.st_fwd !== 1'b0) begin failures++; $display("FAIL rst_st_fwd got=%b exp=0", bus.st_fwd); end
      checks++; if (bus.fwd1_sel !== 2'b00 || bus.fwd2_sel !== 2'b00) begin failures++; $display("FAIL rst_sel got=%b/%b exp=00/00", bus.fwd1_sel, bus.fwd2_sel); end
      checks++; if (bus.id_op1 !== 16'h1111 || bus.id_op2 !== 16'h2222) begin failures++; $display("FAIL rst_op got=%h/%h exp=1111/2222", bus.id_op1, bus.id_op2); end
      do_reset();
   endtask

   task automatic test_fwd_chain();
      do_reset();
      issue(4'd2, 1, 4'd3, 1, 4'd1, 1, 0, 0);              // A: R1 <= R2+R3
      next_cycle();
      issue(4'd1, 1, 4'd6, 1, 4'd1, 1, 0, 0);              // B: R1 <= R1+R6
      #1;
      checks++; if (bus.fwd1_sel !== 2'b11 || bus.id_op1 !== 16'h0005) begin failures++; $display("FAIL ex_fwd got=%b/%h exp=11/0005", bus.fwd1_sel, bus.id_op1); end
      checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL ex_fwd_stall got=%b exp=0", bus.stall); end
      checks++; if (bus.fwd2_sel !== 2'b00 || bus.id_op2 !== 16'h2222) begin failures++; $display("FAIL ex_fwd_op2 got=%b/%h exp=00/2222", bus.fwd2_sel, bus.id_op2); end
      next_cycle();
      issue(4'd1, 1, 4'd0, 0, 4'd9, 0, 0, 0);              // C: EX=B, MEM=A both write R1
      #1;
      checks++; if (bus.fwd1_sel !== 2'b11) begin failures++; $display("FAIL prio_ex got=%b exp=11", bus.fwd1_sel); end
      next_cycle();
      issue(4'd1, 1, 4'd0, 0, 4'd9, 0, 0, 0);              // D: MEM=B, WB=A
      #1;
      checks++; if (bus.fwd1_sel !== 2'b10 || bus.id_op1 !== 16'hBEEF) begin failures++; $display("FAIL prio_mem got=%b/%h exp=10/beef", bus.fwd1_sel, bus.id_op1); end
      next_cycle();
      issue(4'd1, 1, 4'd1, 0, 4'd9, 0, 0, 0);              // E: WB=B; rs2 not used
      #1;
      checks++; if (bus.fwd1_sel !== 2'b01 || bus.id_op1 !== 16'h7777) begin failures++; $display("FAIL wb_fwd got=%b/%h exp=01/7777", bus.fwd1_sel, bus.id_op1); end
      checks++; if (bus.fwd2_sel !== 2'b00 || bus.id_op2 !== 16'h2222) begin failures++; $display("FAIL unused_src got=%b/%h exp=00/2222", bus.fwd2_sel, bus.id_op2); end
   endtask

   task automatic test_load_use();
      do_reset();
      issue(4'd0, 0, 4'd0, 0, 4'd4, 1, 1, 0);              // LD R4
      next_cycle();
      issue(4'd4, 1, 4'd4, 1, 4'd5, 1, 0, 0);              // ADD R5,R4,R4
      #1;
      checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", bus.stall); end
      next_cycle();
      #1;
      checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL lu_release got=%b exp=0", bus.stall); end
      checks++; if (bus.fwd1_sel !== 2'b10 || bus.fwd2_sel !== 2'b10) begin failures++; $display("FAIL lu_sel got=%b/%b exp=10/10", bus.fwd1_sel, bus.fwd2_sel); end
      checks++; if (bus.id_op1 !== 16'hBEEF || bus.id_op2 !== 16'hBEEF) begin failures++; $display("FAIL lu_op got=%h/%h exp=beef/beef", bus.id_op1, bus.id_op2); end
   endtask

   task automatic test_store_fwd();
      logic exp_stall;
      logic exp_st;
`ifdef HAZ_STORE_FWD_EN
      exp_stall = 1'b0;
      exp_st    = 1'b1;
`else
      exp_stall = 1'b1;
      exp_st    = 1'b0;
`endif
      do_reset();
      issue(4'd0, 0, 4'd0, 0, 4'd4, 1, 1, 0);              // LD R4
      next_cycle();
      issue(4'd5, 1, 4'd4, 1, 4'd0, 0, 0, 1);              // ST R4 -> [R5]
      #1;
      checks++; if (bus.stall !== exp_stall) begin failures++; $display("FAIL st_stall got=%b exp=%b", bus.stall, exp_stall); end
      checks++; if (bus.st_fwd !== 1'b0) begin failures++; $display("FAIL st_fwd_early got=%b exp=0", bus.st_fwd); end
      if (exp_stall) next_cycle();                        // store re-presented once
      next_cycle();
      clear_id();
      #1;
      checks++; if (bus.st_fwd !== 1'b0) begin failures++; $display("FAIL st_fwd_ex got=%b exp=0", bus.st_fwd); end
      next_cycle();
      #1;
      checks++; if (bus.st_fwd !== exp_st) begin failures++; $display("FAIL st_fwd_mem got=%b exp=%b", bus.st_fwd, exp_st); end
   endtask

   task automatic test_zero_reg();
      do_reset();
      issue(4'd1, 1, 4'd2, 1, 4'd0, 1, 0, 0);              // writes R0
      next_cycle();
      issue(4'd0, 1, 4'd0, 1, 4'd3, 1, 0, 0);              // reads R0
      #1;
      checks++; if (bus.fwd1_sel !== 2'b00 || bus.id_op1 !== 16'h1111) begin failures++; $display("FAIL zero_reg got=%b/%h exp=00/1111", bus.fwd1_sel, bus.id_op1); end
   endtask

   task automatic test_branch();
      do_reset();
      issue(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0);
      bus.id_branch_taken = 1;
      #1;
      checks++; if (bus.flush !== 1'b1 || bus.stall !== 1'b0) begin failures++; $display("FAIL br_flush got=%b/%b exp=1/0", bus.flush, bus.stall); end
      next_cycle();
      clear_id();
      #1;
      checks++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL br_one_cycle got=%b exp=0", bus.flush); end
      issue(4'd0, 0, 4'd0, 0, 4'd4, 1, 1, 0);              // LD R4
      next_cycle();
      issue(4'd4, 1, 4'd0, 0, 4'd0, 0, 0, 0);              // BEQZ R4, taken
      bus.id_branch_taken = 1;
      #1;
      checks++; if (bus.flush !== 1'b0 || bus.stall !== 1'b1) begin failures++; $display("FAIL br_lu got=%b/%b exp=0/1", bus.flush, bus.stall); end
      next_cycle();
      #1;
      checks++; if (bus.flush !== 1'b1 || bus.stall !== 1'b0) begin failures++; $display("FAIL br_retry got=%b/%b exp=1/0", bus.flush, bus.stall); end
   endtask

   task automatic test_halt();
      do_reset();
      issue(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0);
      bus.id_hlt = 1;
      #1;
      checks++; if (bus.stall !== 1'b0 || bus.hlt !== 1'b0) begin failures++; $display("FAIL hlt_accept got=%b/%b exp=0/0", bus.stall, bus.hlt); end
      next_cycle();
      clear_id();
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (bus.stall !== 1'b1 || bus.flush !== 1'b1 || bus.hlt !== 1'b0) begin failures++; $display("FAIL drain%0d got=%b%b%b exp=110", i, bus.stall, bus.flush, bus.hlt); end
         next_cycle();
      end
      #1;
      checks++; if (bus.hlt !== 1'b1 || bus.stall !== 1'b1 || bus.flush !== 1'b0) begin failures++; $display("FAIL halted got=%b%b%b exp=110", bus.hlt, bus.stall, bus.flush); end
      next_cycle();
      checks++; if (bus.hlt !== 1'b1) begin failures++; $display("FAIL halted_hold got=%b exp=1", bus.hlt); end
   endtask

   task automatic test_reset_mid_drain();
      do_reset();
      issue(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0);
      bus.id_hlt = 1;
      next_cycle();
      clear_id();
      next_cycle();
      #1;
      checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL md_draining got=%b exp=1", bus.stall); end
      rst_n = 0;
      #1;
      checks++; if (bus.stall !== 1'b0 || bus.flush !== 1'b0 || bus.hlt !== 1'b0 || bus.st_fwd !== 1'b0) begin failures++; $display("FAIL md_rst got=%b%b%b%b exp=0000", bus.stall, bus.flush, bus.hlt, bus.st_fwd); end
      checks++; if (bus.id_op1 !== 16'h1111 || bus.fwd1_sel !== 2'b00) begin failures++; $display("FAIL md_rst_op got=%h/%b exp=1111/00", bus.id_op1, bus.fwd1_sel); end
      #1 rst_n = 1;
      repeat (2) next_cycle();
      checks++; if (bus.hlt !== 1'b0 || bus.stall !== 1'b0) begin failures++; $display("FAIL md_after got=%b/%b exp=0/0", bus.hlt, bus.stall); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 0;
      clear_id();
      bus.id_rf1 = 16'h1111;
      bus.id_rf2 = 16'h2222;
      bus.ex_result = 16'h0005;
      bus.mem_data = 16'hBEEF;
      bus.wb_data = 16'h7777;
      test_reset();
      test_fwd_chain();
      test_load_use();
      test_store_fwd();
      test_zero_reg();
      test_branch();
      test_halt();
      test_reset_mid_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
